// File: rtl/quad_decoder.sv
// Quadrature decoder: two-flop sync, optional per-phase glitch filter
// (define QDEC_FILTER_EN), Gray-code step/dir decode and a wrapping position count.
module quad_decoder #(
  parameter int CNT_W    = 8,
  parameter int FILT_LEN = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] d_in,
  input  logic             err_clr,
  output logic             step,
  output logic             dir,
  output logic [CNT_W-1:0] count,
  output logic             err
);

  localparam int WARM_W = $clog2(FILT_LEN + 3);
`ifdef QDEC_FILTER_EN
  localparam int WARM  = FILT_LEN + 1;
  localparam int RUN_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
`else
  localparam int WARM  = 2;
`endif

  // Phase vectors are packed as {A, B}
  logic [1:0]        s1;
  logic [1:0]        s2;
  logic [1:0]        filt;
  logic [1:0]        prev;
  logic              primed;
  logic [WARM_W-1:0] warm;
  logic              mv_up;
  logic              mv_dn;
  logic              mv_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 2'b00;
      s2 <= 2'b00;
    end else begin
      s1 <= {enc_a, enc_b};
      s2 <= s1;
    end
  end

`ifdef QDEC_FILTER_EN
  logic [1:0]       acc;
  logic [RUN_W-1:0] run [2];

  // The current s2 sample counts toward stability, so a change is passed on
  // combinationally in the cycle it completes FILT_LEN consecutive samples.
  always_comb begin
    filt = acc;
    for (int i = 0; i < 2; i++) begin
      if (s2[i] != acc[i] && run[i] == RUN_W'(FILT_LEN - 1)) filt[i] = s2[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= 2'b00;
      run[0] <= '0;
      run[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == acc[i]) begin
          run[i] <= '0;
        end else if (run[i] == RUN_W'(FILT_LEN - 1)) begin
          run[i] <= '0;
          acc[i] <= s2[i];
        end else begin
          run[i] <= run[i] + RUN_W'(1);
        end
      end
    end
  end
`else
  assign filt = s2;
`endif

  // Up order is 00 -> 10 -> 11 -> 01 -> 00; anything changing both bits is illegal
  always_comb begin
    mv_up  = 1'b0;
    mv_dn  = 1'b0;
    mv_bad = 1'b0;
    case ({prev, filt})
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: mv_up = 1'b1;
      4'b10_00, 4'b11_10, 4'b01_11, 4'b00_01: mv_dn = 1'b1;
      4'b00_00, 4'b10_10, 4'b11_11, 4'b01_01: mv_up = 1'b0;
      default:                                mv_bad = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warm <= '0;
    end else if (warm != WARM_W'(WARM)) begin
      warm <= warm + WARM_W'(1);
    end
  end

  // Priming waits until the filtered phases reflect the inputs present at release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev   <= 2'b00;
      primed <= 1'b0;
      step   <= 1'b0;
      dir    <= 1'b0;
      count  <= '0;
      err    <= 1'b0;
    end else begin
      step <= 1'b0;
      if (!primed) begin
        if (warm == WARM_W'(WARM)) begin
          primed <= 1'b1;
          prev   <= filt;
        end
      end else begin
        prev <= filt;
        if (mv_up || mv_dn) begin
          step <= 1'b1;
          dir  <= mv_up;
        end
      end
      err <= (primed & mv_bad) | (err & ~err_clr);
      if (clr)                  count <= '0;
      else if (load)            count <= d_in;
      else if (primed && mv_up) count <= count + CNT_W'(1);
      else if (primed && mv_dn) count <= count - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_quad_decoder.sv
// Self-checking bench for quad_decoder: directed scenarios plus randomized
// encoder motion checked every cycle against a sample-history reference model.
module tb_quad_decoder;

  localparam int CNT_W    = 8;
  localparam int FILT_LEN = 3;
`ifdef QDEC_FILTER_EN
  localparam int MIN = FILT_LEN;
`else
  localparam int MIN = 1;
`endif
  localparam int LAT = MIN + 1;

  logic             clk;
  logic             rst_n;
  logic             enc_a;
  logic             enc_b;
  logic             clr;
  logic             load;
  logic [CNT_W-1:0] d_in;
  logic             err_clr;
  logic             step;
  logic             dir;
  logic [CNT_W-1:0] count;
  logic             err;

  quad_decoder #(.CNT_W(CNT_W), .FILT_LEN(FILT_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .enc_a(enc_a), .enc_b(enc_b),
    .clr(clr), .load(load), .d_in(d_in), .err_clr(err_clr),
    .step(step), .dir(dir), .count(count), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests    = 0;
  int failures = 0;

  // Reference model state: accepted phase levels, recent s1 samples, position
  bit fa, fb;
  bit sa[$];
  bit sb[$];
  int prev_pos;
  bit primed_m;
  int edges;
  bit exp_step, exp_dir, exp_err;
  int exp_cnt;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic int posOf(bit a, bit b);
    if (a) return b ? 2 : 1;
    return b ? 3 : 0;
  endfunction

  function automatic logic [1:0] bitsOf(int p);
    case (p % 4)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  task automatic modelReset();
    fa = 0; fb = 0;
    sa.delete(); sb.delete();
    repeat (MIN) begin sa.push_back(1'b0); sb.push_back(1'b0); end
    prev_pos = 0; primed_m = 0; edges = 0;
    exp_step = 0; exp_dir = 0; exp_err = 0; exp_cnt = 0;
  endtask

  // One rising edge; arguments are the inputs held just before that edge
  task automatic modelEdge(input bit a, input bit b, input bit c, input bit l,
                           input logic [7:0] d, input bit ec);
    int cur, delta;
    bit up, dn, bad, all_a, all_b;
    cur = posOf(fa, fb);
    up = 0; dn = 0; bad = 0;
    exp_step = 0;
    edges++;
    if (!primed_m) begin
      if (edges == MIN + 2) begin primed_m = 1; prev_pos = cur; end
    end else begin
      delta = (cur - prev_pos + 4) % 4;
      prev_pos = cur;
      up  = (delta == 1);
      dn  = (delta == 3);
      bad = (delta == 2);
    end
    if (up || dn) begin exp_step = 1; exp_dir = up; end
    exp_err = bad || (exp_err && !ec);
    if (c)       exp_cnt = 0;
    else if (l)  exp_cnt = int'(d);
    else if (up) exp_cnt = (exp_cnt + 1) % 256;
    else if (dn) exp_cnt = (exp_cnt + 255) % 256;
    all_a = 1; all_b = 1;
    for (int i = 0; i < sa.size(); i++) begin
      if (sa[i] != sa[sa.size()-1]) all_a = 0;
      if (sb[i] != sb[sb.size()-1]) all_b = 0;
    end
    if (all_a) fa = sa[sa.size()-1];
    if (all_b) fb = sb[sb.size()-1];
    sa.push_back(a); sb.push_back(b);
    while (sa.size() > MIN) void'(sa.pop_front());
    while (sb.size() > MIN) void'(sb.pop_front());
  endtask

  task automatic applyStimulus(input bit a, input bit b, input bit c, input bit l,
                               input logic [7:0] d, input bit ec, input int n);
    repeat (n) begin
      enc_a = a; enc_b = b; clr = c; load = l; d_in = d; err_clr = ec;
      @(posedge clk);
      modelEdge(a, b, c, l, d, ec);
      #1;
      checkOutput("step", step, exp_step);
      checkOutput("dir", dir, exp_dir);
      checkOutput("count", count, exp_cnt);
      checkOutput("err", err, exp_err);
    end
  endtask

  task automatic doReset();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_step", step, 0);
    checkOutput("rst_dir", dir, 0);
    checkOutput("rst_count", count, 0);
    checkOutput("rst_err", err, 0);
    modelReset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int enc_p, r, hold;
    logic [1:0] v;
    rst_n = 1'b1; enc_a = 0; enc_b = 0; clr = 0; load = 0; d_in = '0; err_clr = 0;
    #2 rst_n = 1'b0;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("init_step", step, 0);
    checkOutput("init_dir", dir, 0);
    checkOutput("init_count", count, 0);
    checkOutput("init_err", err, 0);
    rst_n = 1'b1;

    // Full up cycle
    applyStimulus(0, 0, 0, 0, 8'h00, 0, 10);
    applyStimulus(1, 0, 0, 0, 8'h00, 0, 10);
    applyStimulus(1, 1, 0, 0, 8'h00, 0, 10);
    applyStimulus(0, 1, 0, 0, 8'h00, 0, 10);
    applyStimulus(0, 0, 0, 0, 8'h00, 0, 10);
    checkOutput("up_count", count, 4);
    checkOutput("up_dir", dir, 1);

    // Down from zero wraps to all-ones
    applyStimulus(0, 0, 1, 0, 8'h00, 0, 1);
    applyStimulus(0, 1, 0, 0, 8'h00, 0, 10);
    checkOutput("down_count", count, 8'hFF);
    checkOutput("down_dir", dir, 0);

    // Load lands on the same edge as an up step
    applyStimulus(0, 0, 0, 0, 8'h00, 0, LAT);
    applyStimulus(0, 0, 0, 1, 8'hFE, 0, 1);
    checkOutput("load_step", step, 1);
    checkOutput("load_count", count, 8'hFE);
    applyStimulus(0, 0, 0, 0, 8'h00, 0, 8);

    // Short glitch rejected, minimum-length pulse accepted (up then back down)
    if (MIN > 1) applyStimulus(1, 0, 0, 0, 8'h00, 0, MIN - 1);
    applyStimulus(0, 0, 0, 0, 8'h00, 0, 10);
    checkOutput("glitch_count", count, 8'hFE);
    applyStimulus(1, 0, 0, 0, 8'h00, 0, MIN);
    applyStimulus(0, 0, 0, 0, 8'h00, 0, 12);
    checkOutput("pulse_count", count, 8'hFE);

    // Up across the all-ones boundary
    applyStimulus(1, 0, 0, 0, 8'h00, 0, 10);
    applyStimulus(1, 1, 0, 0, 8'h00, 0, 10);
    checkOutput("wrap_count", count, 0);

    // Illegal jumps and sticky error priority
    applyStimulus(0, 0, 0, 0, 8'h00, 0, 10);
    checkOutput("jump_err", err, 1);
    checkOutput("jump_count", count, 0);
    applyStimulus(1, 1, 0, 0, 8'h00, 0, LAT);
    applyStimulus(1, 1, 0, 0, 8'h00, 1, 1);
    checkOutput("setclr_err", err, 1);
    applyStimulus(1, 1, 0, 0, 8'h00, 0, 8);
    applyStimulus(1, 1, 0, 0, 8'h00, 1, 1);
    checkOutput("errclr_err", err, 0);
    applyStimulus(1, 1, 0, 0, 8'h00, 0, 4);

    // Release reset with both phases high
    doReset();
    applyStimulus(1, 1, 0, 0, 8'h00, 0, 15);
    checkOutput("prime_err", err, 0);
    checkOutput("prime_count", count, 0);
    applyStimulus(0, 1, 0, 0, 8'h00, 0, 10);
    checkOutput("prime_up_count", count, 1);
    checkOutput("prime_up_dir", dir, 1);

    // Reset mid-operation, then clear beats load
    applyStimulus(0, 1, 0, 1, 8'h05, 0, 1);
    applyStimulus(0, 1, 0, 0, 8'h00, 0, 3);
    checkOutput("pre_rst_count", count, 5);
    doReset();
    applyStimulus(0, 1, 0, 1, 8'h33, 0, 1);
    applyStimulus(0, 1, 1, 1, 8'hAA, 0, 1);
    checkOutput("clrload_count", count, 0);
    applyStimulus(0, 1, 0, 0, 8'h00, 0, 5);

    // Random motion with glitches, jumps and sporadic controls
    enc_p = posOf(enc_a, enc_b);
    for (int s = 0; s < 300; s++) begin
      r = int'($urandom_range(0, 9));
      if (r < 4)      enc_p = (enc_p + 1) % 4;
      else if (r < 8) enc_p = (enc_p + 3) % 4;
      else            enc_p = (enc_p + 2) % 4;
      v = bitsOf(enc_p);
      hold = int'($urandom_range(1, MIN + 5));
      for (int h = 0; h < hold; h++) begin
        applyStimulus(v[1], v[0], $urandom_range(0, 19) == 0, $urandom_range(0, 14) == 0,
                      8'($urandom), $urandom_range(0, 7) == 0, 1);
      end
      if (s == 150) doReset();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/quad_decoder.md
# quad_decoder

Quadrature decoder for two-phase incremental-encoder inputs. Synchronizes and glitch-filters the asynchronous A/B phases, decodes Gray-code transitions into single-cycle step pulses with a direction flag, and maintains a loadable wrapping position count. It drives the up/down counting path: its `step`/`dir` outputs map directly onto a counter's enable/up-down controls, and its internal `count` mirrors that counter for local use.

## Interface
- `CNT_W`, 8, width of position count and load value
- `FILT_LEN`, 3, consecutive stable synchronized samples needed before a phase change is accepted (≥1)

- `clk` in 1: clock; all state on rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `enc_a` in 1: encoder phase A, asynchronous to `clk`
- `enc_b` in 1: encoder phase B, asynchronous to `clk`
- `clr` in 1: synchronous clear of `count`
- `load` in 1: synchronous load of `count` from `d_in`
- `d_in` in CNT_W: load value
- `err_clr` in 1: clears sticky `err`
- `step` out 1: one-cycle pulse per legal transition
- `dir` out 1: direction of last legal step (1 = up, 0 = down)
- `count` out CNT_W: position count
- `err` out 1: sticky illegal-transition flag

## Operation
- Reset values: `step`=0, `dir`=0, `count`=0, `err`=0; sync, filter and previous-state registers 0; `primed`=0.
- Sync: each phase passes through two flops (`s1`, `s2`).
- Filter: per-phase counter; when `s2` differs from filtered value for FILT_LEN consecutive cycles, filtered value takes `s2`; any cycle with `s2` equal to filtered value zeroes the counter.
- Decode state `{A,B}` from filtered values; `prev` holds last decoded state.
- Priming: first filter-valid cycle after reset (FILT_LEN+1 cycles after `rst_n` deassertion) loads `prev` with current state, sets `primed`, no step/err.
- Up sequence: 00→10→11→01→00. Down: reverse. Each legal change: `step`=1 one cycle, `dir` updated, `count` ±1.
- Both bits change in one decode cycle: `err` set, no step, `count` and `dir` unchanged, `prev` updated to new state.
- No change: `step`=0, all else held.
- `count` arithmetic modulo 2^CNT_W: all-ones +1 → 0; 0 −1 → all-ones.
- Count priority: `clr` > `load` > step. `step`/`dir` reflect decode regardless of `clr`/`load`.
- `err`: set by illegal transition, cleared by `err_clr`; simultaneous set and clear → `err`=1.
- `rst_n` asserted mid-operation: all registers return to reset values immediately; priming repeats after release.

## Timing
- Phase change first captured by `s1` at edge k: `s2` at k+1, filtered value at k+FILT_LEN, `step`/`dir`/`count`/`err` at k+FILT_LEN+1.
- Pulse shorter than FILT_LEN cycles at `s2`: rejected, no output.
- `clr`, `load`, `err_clr`: effective at next edge, one-cycle latency.
- `step` never high two consecutive cycles for one phase edge; max legal step rate one per FILT_LEN cycles.

## Configuration
- `QDEC_FILTER_EN` defined: filter present as above, latency FILT_LEN+1 from `s1` capture.
- Not defined: filter removed, decode runs directly on `s2` (equivalent to FILT_LEN=1); latency 2 cycles from `s1` capture; FILT_LEN ignored; priming occurs 2 cycles after reset release.

## Test plan
- Reset, hold A=B=0, apply up sequence 00→10→11→01→00 with 10-cycle spacing, FILT_LEN=3 → four `step` pulses, `dir`=1, `count` 0→4, each pulse 4 cycles after `s1` capture.
- From `count`=0, one down step (00→01) → `count`=8'hFF, `dir`=0; then `load` d_in=8'hFE and up step same cycle → `count`=8'hFE, `step`=1.
- Toggle A high for 2 cycles only (FILT_LEN=3) → no `step`, `count` unchanged; 3-cycle pulse → accepted.
- Jump 00→11 → `err`=1, no step, `count` unchanged; assert `err_clr` with simultaneous 11→00 jump → `err` stays 1; `err_clr` alone → `err`=0.
- Release reset with A=B=1 held → no step, no err after priming; next 11→01 → up step.
- Assert `rst_n` low mid-sequence with `count`=5 → all outputs 0 immediately; `clr` and `load` together → `count`=0.
